gobou_serial_wb: RTL
====================

# gobou_serial_wb

Write-back stage directly downstream of the gobou ReLU stage: consumes each CORE-lane parallel result group announced by the relu `out_begin/out_valid/out_end` handshake and serialises it, one lane per cycle, into image memory at consecutive output addresses. Two result banks (ping-pong) let a new group arrive while the previous one drains. It also signals layer completion back to the core controller.

## Interface
Parameters:
- DWIDTH, 16, data word width
- CORE, 8, lanes per result group
- CORELOG, 3, log2(CORE)
- IMGSIZE, 12, image memory address width
- LWIDTH, 10, layer size counter width

Ports:
- clk  in  1  clock; all state changes on rising edge
- xrst  in  1  reset; asynchronous, active-low
- in_begin  in  1  one-cycle pulse, layer start (from relu out_begin)
- in_valid  in  1  one-cycle pulse, relu_result holds a valid group (from relu out_valid)
- in_end  in  1  one-cycle pulse, no more groups this layer (from relu out_end)
- relu_result  in  CORE*DWIDTH  signed lanes; lane i = bits [i*DWIDTH +: DWIDTH]
- output_addr  in  IMGSIZE  base write address, sampled at in_begin
- total_out  in  LWIDTH  number of outputs in layer, sampled at in_begin
- mem_img_we  out  1  image memory write enable
- mem_img_addr  out  IMGSIZE  image memory write address
- write_result  out  DWIDTH signed  write data
- busy  out  1  high from in_begin until out_end
- out_end  out  1  one-cycle pulse, all writes done
- overflow  out  1  sticky, a group was dropped

## Operation
- States: IDLE, ACTIVE, FLUSH. Reset -> IDLE.
- IDLE --in_begin--> ACTIVE: latch output_addr, total_out; out_count=0; clear both banks, overflow, pending-end.
- in_begin in any state: same action (abort; buffered data discarded, no further writes from old layer).
- ACTIVE: in_valid captures relu_result into the free bank (bank 0 preferred when both free; else the one not draining). Banks drain in arrival order.
- Drain: one lane per cycle, lane 0..CORE-1. Each lane with out_count < total_out: mem_img_we=1, mem_img_addr=(base+out_count) mod 2^IMGSIZE, write_result=lane, out_count++. Once out_count == total_out, remaining lanes of the bank and all later groups are discarded with no write (bank freed immediately).
- A bank is free in the same cycle its last lane is issued; in_valid that cycle is accepted into it.
- in_valid with both banks occupied (after the above rule): group dropped, overflow=1 until next in_begin/reset.
- in_valid in IDLE: ignored, no overflow.
- in_end in ACTIVE -> FLUSH. FLUSH: drain remaining banks; in_valid in FLUSH ignored. When both banks empty and no write issued this cycle: out_end=1 for one cycle, busy=0, -> IDLE.
- total_out=0: no writes ever; out_end follows in_end normally.

## Timing
- Reset values: mem_img_we=0, mem_img_addr=0, write_result=0, busy=0, out_end=0, overflow=0; banks empty, out_count=0.
- All outputs registered. in_valid at cycle t -> first write (lane 0) visible at t+1; lane i at t+1+i if bank was idle.
- busy rises cycle after in_begin.
- in_end at t with banks empty -> out_end at t+1. Otherwise out_end in cycle after the last mem_img_we.
- in_end and in_valid same cycle: group accepted first, then FLUSH.
- in_begin and in_valid same cycle: in_begin wins, group ignored.
- mem_img_addr and write_result hold last value when mem_img_we=0.

## Test plan
- CORE=8, total_out=8, base=0x100: in_begin, in_valid with lanes 1..8, in_end -> writes 0x100..0x107 data 1..8 at cycles t+1..t+8, out_end one cycle after last write, overflow=0.
- total_out=10, two groups 8 cycles apart (lanes 0..7, 10..17) -> 10 writes, addr base..base+9, data 0..7,10,11; lanes 12..17 never written.
- Three in_valid on consecutive cycles -> first two drain back-to-back (16 writes), third dropped, overflow=1, cleared by next in_begin.
- in_valid exactly on cycle of bank 0's lane-7 issue with bank 1 full -> accepted, no overflow, 24 consecutive writes.
- base=0xFFE, total_out=4 -> addresses 0xFFE,0xFFF,0x000,0x001.
- xrst low mid-drain, and separately in_begin mid-drain -> outputs to reset values / writes stop next cycle, out_count restarts at 0.

Source files
------------

// File: rtl/gobou_serial_wb.sv
// gobou_serial_wb: write-back stage after the ReLU stage.
// Serialises CORE-lane groups into image memory through two ping-pong banks.
module gobou_serial_wb #(
    parameter int DWIDTH  = 16,
    parameter int CORE    = 8,
    parameter int CORELOG = 3,
    parameter int IMGSIZE = 12,
    parameter int LWIDTH  = 10
) (
    input  logic                      clk,
    input  logic                      xrst,
    input  logic                      in_begin,
    input  logic                      in_valid,
    input  logic                      in_end,
    input  logic [CORE*DWIDTH-1:0]    relu_result,
    input  logic [IMGSIZE-1:0]        output_addr,
    input  logic [LWIDTH-1:0]         total_out,
    output logic                      mem_img_we,
    output logic [IMGSIZE-1:0]        mem_img_addr,
    output logic signed [DWIDTH-1:0]  write_result,
    output logic                      busy,
    output logic                      out_end,
    output logic                      overflow
);

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_e;

    state_e                        state_q, state_d;
    logic [IMGSIZE-1:0]            base_q, base_d;
    logic [LWIDTH-1:0]             total_q, total_d;
    logic [LWIDTH-1:0]             cnt_q, cnt_d;
    logic [CORELOG-1:0]            lane_q, lane_d;
    logic                          head_q, head_d;
    logic [1:0]                    full_q, full_d;
    logic [1:0][CORE*DWIDTH-1:0]   bank_q, bank_d;
    logic                          we_q, we_d;
    logic [IMGSIZE-1:0]            addr_q, addr_d;
    logic [DWIDTH-1:0]             data_q, data_d;
    logic                          busy_q, busy_d;
    logic                          end_q, end_d;
    logic                          ovf_q, ovf_d;

    logic                          issue;
    logic                          take;
    logic                          sel;
    logic                          put;
    logic                          last;
    logic [CORELOG-1:0]            ilane;
    logic [CORE*DWIDTH-1:0]        src;
    logic [DWIDTH-1:0]             word;
    logic [LWIDTH:0]               cnt_inc;

    // Next state: abort/start, lane issue from the head bank (or straight
    // from the input when both banks are idle), capture, and end detection.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        total_d = total_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        head_d  = head_q;
        full_d  = full_q;
        bank_d  = bank_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        busy_d  = busy_q;
        end_d   = 1'b0;
        ovf_d   = ovf_q;
        issue   = 1'b0;
        take    = 1'b0;
        sel     = head_q;
        put     = 1'b0;
        last    = 1'b0;
        ilane   = lane_q;
        src     = bank_q[head_q];
        word    = '0;
        cnt_inc = {1'b0, cnt_q} + {{LWIDTH{1'b0}}, 1'b1};

        if (in_begin) begin
            state_d = ACTIVE;
            busy_d  = 1'b1;
            base_d  = output_addr;
            total_d = total_out;
            cnt_d   = '0;
            lane_d  = '0;
            head_d  = 1'b0;
            full_d  = '0;
            ovf_d   = 1'b0;
        end else if (state_q != IDLE) begin
            take  = in_valid && (state_q == ACTIVE);
            issue = full_q[head_q];
            // Idle banks: the new group goes to bank 0 and lane 0 issues now.
            if (!issue && take) begin
                issue     = 1'b1;
                take      = 1'b0;
                sel       = 1'b0;
                src       = relu_result;
                ilane     = '0;
                full_d[0] = 1'b1;
                bank_d[0] = relu_result;
            end
            if (issue) begin
                for (int i = 0; i < CORE; i++) begin
                    if (ilane == CORELOG'(i)) begin
                        word = src[i*DWIDTH +: DWIDTH];
                    end
                end
                if (cnt_q < total_q) begin
                    we_d   = 1'b1;
                    addr_d = base_q + IMGSIZE'(cnt_q);
                    data_d = word;
                    cnt_d  = cnt_q + LWIDTH'(1);
                end
                // Layer quota reached: the rest of the bank is dropped.
                last = (ilane == CORELOG'(CORE - 1)) ||
                       (cnt_inc >= {1'b0, total_q});
                if (last) begin
                    full_d[sel] = 1'b0;
                    head_d      = ~sel;
                    lane_d      = '0;
                end else begin
                    head_d      = sel;
                    lane_d      = ilane + CORELOG'(1);
                end
            end
            if (take) begin
                if (!full_d[0] || !full_d[1]) begin
                    put = full_d[0];
                    if (!full_d[head_d]) begin
                        head_d = put;
                    end
                    full_d[put] = 1'b1;
                    bank_d[put] = relu_result;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            if ((state_q == FLUSH || in_end) && !we_d && full_d == 2'b00) begin
                end_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end else if (in_end) begin
                state_d = FLUSH;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q <= IDLE;
            base_q  <= '0;
            total_q <= '0;
            cnt_q   <= '0;
            lane_q  <= '0;
            head_q  <= 1'b0;
            full_q  <= '0;
            bank_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            end_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            total_q <= total_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            head_q  <= head_d;
            full_q  <= full_d;
            bank_q  <= bank_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            end_q   <= end_d;
            ovf_q   <= ovf_d;
        end
    end

    assign mem_img_we   = we_q;
    assign mem_img_addr = addr_q;
    assign write_result = data_q;
    assign busy         = busy_q;
    assign out_end      = end_q;
    assign overflow     = ovf_q;

endmodule
